fc_mulxnor_fold_pipe: RTL
=========================

Name: fc_mulxnor_fold_pipe

Overview:
Folded, pipelined unary fully-connected multiplier stage for uBrain.
- Time-multiplexes ODIM output neurons over FOLD passes. Each pass consumes a BLEN-cycle input bitstream.
- Each cycle, multiplies every input bit by the weight-bit slice of the active fold: XNOR in bipolar mode, AND in unipolar mode.
- Drives the resulting product bitstreams through a PIPE-deep register pipeline to the downstream adder tree, tagged with valid, fold and end-of-stream flags.

Parameters:
IDIM, 4, input neuron count (bits per cycle on iBit).
ODIM, 4, output neuron count; must be divisible by FOLD.
FOLD, 2, number of time-multiplexed passes; OPF = ODIM/FOLD outputs per pass.
BLEN, 4, bitstream length (valid cycles) per fold; must be >= 2.
PIPE, 2, output register stages; must be >= 1.

Ports:
clk  input  1  clock.
rst  input  1  reset: synchronous, active-high.
start  input  1  one-cycle pulse; begins a job when idle.
mode  input  1  0 = bipolar XNOR, 1 = unipolar AND; sampled on accepted start.
iValid  input  1  iBit holds a valid stream bit this cycle.
iReady  output  1  high while in RUN.
iBit  input  IDIM  input stream bits.
wBit  input  ODIM*IDIM  weight bits; index o*IDIM+i; must be stable for the whole job.
oValid  output  1  oFmbs valid.
oFmbs  output  OPF*IDIM  product bits; index j*IDIM+i.
oFold  output  clog2(FOLD) (min 1)  fold index of the current oFmbs.
oLast  output  1  marks the final (BLEN-th) bit of a fold's stream.
done  output  1  one-cycle pulse when a job is fully drained.

Behaviour:
Reset:
- On rst high at a clock edge: state=IDLE; cnt=0; fold=0; mode register=0; all pipeline valid/last bits=0; oFmbs=0; oFold=0; done=0.
- Reset overrides every other input, including mid-job. All in-flight data is discarded and no done pulse is issued.

States:
- IDLE: iReady=0. start=1 -> RUN, cnt=0, fold=0, mode latched.
- RUN: iReady=1. Each cycle with iValid=1, compute for j in [0,OPF), i in [0,IDIM):
  p[j*IDIM+i] = mode ? (iBit[i] & w) : ~(iBit[i] ^ w), where w = wBit[(fold*OPF+j)*IDIM+i].
  - p enters pipeline stage 0 with valid=1, fold tag=fold, last=(cnt==BLEN-1).
  - Then cnt++. When cnt==BLEN-1: cnt=0 and fold++. If fold==FOLD-1 at that point: fold=0 and go to DRAIN.
- RUN with iValid=0: counters hold; a bubble (valid=0) enters the pipeline. Data bits in the bubble are don't-care but held at their previous value.
- DRAIN: iReady=0; input ignored. Wait until all PIPE stages have valid=0, then assert done for exactly one cycle and go to IDLE.

Pipeline:
- PIPE-stage shift register. Latency from an accepted iValid cycle to oValid is exactly PIPE cycles.
- No backpressure: the downstream consumer must accept every oValid cycle.
- oFmbs, oFold and oLast are taken from the final stage.

Boundary conditions:
- start while RUN or DRAIN: ignored.
- start in the same cycle that done is asserted: ignored.
- iValid while IDLE or DRAIN: ignored.
- Fold advance and last flag occur on the same cycle. The final fold's last accepted bit causes the RUN->DRAIN transition in that cycle.
- Exactly FOLD*BLEN oValid cycles per job.
- done asserts PIPE+1 cycles after the final accepted input (the extra cycle is for the empty check).
- mode or wBit changes mid-job: behaviour undefined (not supported).

Test Plan:
1. Reset sequencing: assert rst for 2 cycles mid-RUN -> following cycle iReady=0, oValid=0, done=0; any later oValid appears only after a new start.
2. Bipolar basic (IDIM=4, ODIM=4, FOLD=2, BLEN=4, PIPE=2):
   - Stimulus: fold0 rows wBit=4'b1111, fold1 rows wBit=4'b0000; iBit=4'b1010 every cycle; iValid held high.
   - Required: oFmbs=8'b1010_1010 for 4 cycles with oFold=0, then 8'b0101_0101 for 4 cycles with oFold=1.
   - First oValid 2 cycles after first accept; oLast on cycles 4 and 8; done 3 cycles after last accept.
3. Unipolar: same stimulus with mode=1 -> fold0 outputs 8'b1010_1010, fold1 outputs 8'h00.
4. Stalls: iValid pattern 1,0,0,1,1,0,1,... -> oValid reproduces the same pattern delayed by 2 cycles; exactly 8 valid outputs per job; fold switches after the 4th valid.
5. Ignored controls: start pulse during RUN and iValid during DRAIN -> no change to counters, output count or done timing.
6. Back-to-back jobs: start pulse in the cycle after done -> a second job produces identical output, with mode re-latched from its own start.

Source files
------------

// File: rtl/fc_mulxnor_fold_pipe_if.sv
// Bus bundle for the folded XNOR/AND unary multiplier stage: job control,
// input bitstream, weights and the tagged product stream to the adder tree.
interface fc_mulxnor_fold_pipe_if #(
    parameter int IDIM = 4,
    parameter int ODIM = 4,
    parameter int FOLD = 2
) ();
    localparam int OPF = ODIM / FOLD;
    localparam int FW  = (FOLD > 1) ? $clog2(FOLD) : 1;

    logic                   start;
    logic                   mode;
    logic                   iValid;
    logic                   iReady;
    logic [IDIM-1:0]        iBit;
    logic [ODIM*IDIM-1:0]   wBit;
    logic                   oValid;
    logic [OPF*IDIM-1:0]    oFmbs;
    logic [FW-1:0]          oFold;
    logic                   oLast;
    logic                   done;

    modport master (
        output start, mode, iValid, iBit, wBit,
        input  iReady, oValid, oFmbs, oFold, oLast, done
    );

    modport slave (
        input  start, mode, iValid, iBit, wBit,
        output iReady, oValid, oFmbs, oFold, oLast, done
    );
endinterface

// File: rtl/fc_mulxnor_fold_pipe.sv
// Folded, pipelined unary fully-connected multiplier stage.
// ODIM outputs are served in FOLD passes of BLEN valid input cycles each; every
// accepted cycle multiplies the input bits by the active fold's weight slice
// (XNOR bipolar / AND unipolar) and pushes the products through PIPE registers.
module fc_mulxnor_fold_pipe #(
    parameter int IDIM = 4,
    parameter int ODIM = 4,
    parameter int FOLD = 2,
    parameter int BLEN = 4,
    parameter int PIPE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    fc_mulxnor_fold_pipe_if.slave     io_bus
);
    localparam int OPF = ODIM / FOLD;
    localparam int PW  = OPF * IDIM;
    localparam int FW  = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam int CW  = (BLEN > 1) ? $clog2(BLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(BLEN - 1);
    localparam logic [FW-1:0] FOLD_LAST = FW'(FOLD - 1);

    // DONE is the single cycle in which the drained pipeline reports completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Product of one input cycle against the weight rows of the selected fold.
    function automatic logic [PW-1:0] f_product(
        input logic                 mode_b,
        input logic [IDIM-1:0]      bits,
        input logic [ODIM*IDIM-1:0] wts,
        input logic [FW-1:0]        fold_idx
    );
        logic [PW-1:0] p;
        logic          w;
        p = '0;
        for (int j = 0; j < OPF; j++) begin
            for (int i = 0; i < IDIM; i++) begin
                w = wts[(int'(fold_idx) * OPF + j) * IDIM + i];
                p[j*IDIM+i] = mode_b ? (bits[i] & w) : ~(bits[i] ^ w);
            end
        end
        return p;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [FW-1:0]    r_fold_cnt;
    logic             r_mode;
    logic [PIPE-1:0]  r_vld;
    logic [PIPE-1:0]  r_last;
    logic [PW-1:0]    r_data [PIPE];
    logic [FW-1:0]    r_fold [PIPE];

    logic             w_start_acc;
    logic             w_accept;
    logic             w_cnt_last;
    logic             w_fold_last;
    logic             w_job_end;
    logic             w_drain_empty;
    logic [PW-1:0]    w_prod;

    assign w_start_acc = (r_state == ST_IDLE) & io_bus.start;
    assign w_accept    = (r_state == ST_RUN) & io_bus.iValid;
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_fold_last = (r_fold_cnt == FOLD_LAST);
    assign w_job_end   = w_accept & w_cnt_last & w_fold_last;
    assign w_prod      = f_product(r_mode, io_bus.iBit, io_bus.wBit, r_fold_cnt);

    // Pipeline will be empty next cycle once every stage but the last is empty
    // (nothing new enters while draining).
    always_comb begin
        w_drain_empty = 1'b1;
        for (int k = 0; k < PIPE - 1; k++) begin
            w_drain_empty = w_drain_empty & ~r_vld[k];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: job start, end of final fold, drain completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_start_acc   ? ST_RUN  : ST_IDLE;
            ST_RUN:   w_state_nxt = w_job_end     ? ST_DRAIN : ST_RUN;
            ST_DRAIN: w_state_nxt = w_drain_empty ? ST_DONE : ST_DRAIN;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs and final pipeline stage to the bus.
    always_comb begin
        io_bus.iReady = 1'b0;
        io_bus.done   = 1'b0;
        case (r_state)
            ST_RUN:  io_bus.iReady = 1'b1;
            ST_DONE: io_bus.done   = 1'b1;
            default: io_bus.iReady = 1'b0;
        endcase
        io_bus.oValid = r_vld[PIPE-1];
        io_bus.oLast  = r_last[PIPE-1];
        io_bus.oFmbs  = r_data[PIPE-1];
        io_bus.oFold  = r_fold[PIPE-1];
    end

    // Bit and fold counters plus the mode latched when a job is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_fold_cnt <= '0;
            r_mode     <= 1'b0;
        end else if (w_start_acc) begin
            r_cnt      <= '0;
            r_fold_cnt <= '0;
            r_mode     <= io_bus.mode;
        end else if (w_accept) begin
            if (w_cnt_last) begin
                r_cnt      <= '0;
                r_fold_cnt <= w_fold_last ? '0 : (r_fold_cnt + FW'(1));
            end else begin
                r_cnt      <= r_cnt + CW'(1);
            end
        end
    end

    // Product pipeline; bubbles keep stage-0 data and carry valid=0, last=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int k = 0; k < PIPE; k++) begin
                r_data[k] <= '0;
                r_fold[k] <= '0;
            end
        end else begin
            r_vld[0]  <= w_accept;
            r_last[0] <= w_accept & w_cnt_last;
            r_data[0] <= w_accept ? w_prod : r_data[0];
            r_fold[0] <= w_accept ? r_fold_cnt : r_fold[0];
            for (int k = 1; k < PIPE; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_last[k] <= r_last[k-1];
                r_data[k] <= r_data[k-1];
                r_fold[k] <= r_fold[k-1];
            end
        end
    end
endmodule
